// File: rtl/hazard_control_unit_if.sv
// Pipeline-side hazard bus: hazard inputs from ID/EX/MEM/WB and the control,
// forwarding and status outputs back to the pipeline registers and PC.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned REG_W = 5;

    // ID stage
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    // EX stage
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch;
    logic             ex_zero;
    logic             ex_jump;
    // MEM stage
    logic [REG_W-1:0] mem_rd;
    logic             mem_reg_write;
    logic             mem_access;
    logic             dmem_ready;
    // WB stage
    logic [REG_W-1:0] wb_rd;
    logic             wb_reg_write;

    // Pipeline control
    logic             pc_write;
    logic             pc_sel;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             global_stall;
    logic             mem_abort;
    logic             mem_fault;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             state_o;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch, ex_zero, ex_jump,
        output mem_rd, mem_reg_write, mem_access, dmem_ready,
        output wb_rd, wb_reg_write,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
        input  global_stall, mem_abort, mem_fault, fwd_a, fwd_b, state_o,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch, ex_zero, ex_jump,
        input  mem_rd, mem_reg_write, mem_access, dmem_ready,
        input  wb_rd, wb_reg_write,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
        output global_stall, mem_abort, mem_fault, fwd_a, fwd_b, state_o,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage RISC-V pipeline: forwarding, load-use stall,
// branch/jump flush, data-memory freeze with timeout, perf counters.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave io_hcu
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_fault;
    logic              w_mem_fault_nxt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;

    logic w_mem_busy;
    logic w_take;
    logic w_hit_rs1;
    logic w_hit_rs2;
    logic w_load_use;
    logic w_timeout;
    logic w_freeze;
    logic w_flush;
    logic w_lu_stall;

    logic w_pc_write;
    logic w_pc_sel;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_global_stall;

    // Forwarding source: MEM result is newer than WB, x0 is hardwired zero
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_mem_busy = io_hcu.mem_access & ~io_hcu.dmem_ready;
    assign w_take     = (io_hcu.ex_branch & io_hcu.ex_zero) | io_hcu.ex_jump;
    assign w_hit_rs1  = io_hcu.id_uses_rs1 & (io_hcu.id_rs1 == io_hcu.ex_rd);
    assign w_hit_rs2  = io_hcu.id_uses_rs2 & (io_hcu.id_rs2 == io_hcu.ex_rd);
    assign w_load_use = io_hcu.ex_mem_read & (io_hcu.ex_rd != '0) & (w_hit_rs1 | w_hit_rs2);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_fault <= w_mem_fault_nxt;
        end
    end

    // Next state and pipeline control; freeze outranks flush outranks load-use
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_fault_nxt = 1'b0;
        w_timeout       = 1'b0;
        w_freeze        = 1'b0;
        w_flush         = 1'b0;
        w_lu_stall      = 1'b0;
        w_pc_write      = 1'b1;
        w_pc_sel        = 1'b0;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_global_stall  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // Ready, or access withdrawn: leave the wait without a fault
                if (!w_mem_busy) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    w_timeout       = 1'b1;
                    w_mem_fault_nxt = 1'b1;
                    w_state_nxt     = ST_RUN;
                    w_wait_cnt_nxt  = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase

        w_freeze = w_mem_busy & ~w_timeout;

        if (w_freeze) begin
            w_global_stall = 1'b1;
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
        end else if (w_take) begin
            w_flush       = 1'b1;
            w_pc_sel      = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_lu_stall    = 1'b1;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if ((w_global_stall | w_lu_stall) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign io_hcu.fwd_a        = fwd_sel(io_hcu.ex_rs1, io_hcu.mem_rd, io_hcu.mem_reg_write,
                                         io_hcu.wb_rd, io_hcu.wb_reg_write);
    assign io_hcu.fwd_b        = fwd_sel(io_hcu.ex_rs2, io_hcu.mem_rd, io_hcu.mem_reg_write,
                                         io_hcu.wb_rd, io_hcu.wb_reg_write);
    assign io_hcu.pc_write     = w_pc_write;
    assign io_hcu.pc_sel       = w_pc_sel;
    assign io_hcu.if_id_write  = w_if_id_write;
    assign io_hcu.if_id_flush  = w_if_id_flush;
    assign io_hcu.id_ex_flush  = w_id_ex_flush;
    assign io_hcu.global_stall = w_global_stall;
    assign io_hcu.mem_abort    = w_timeout;
    assign io_hcu.mem_fault    = r_mem_fault;
    assign io_hcu.state_o      = r_state;
    assign io_hcu.stall_cycles = r_stall_cycles;
    assign io_hcu.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a wide-counter and a 3-bit-counter
// instance share stimulus and are checked each cycle against a rule model.
module tb_hazard_control_unit;
    localparam int unsigned TO = 4;
    localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX_B = 7;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    hazard_control_unit_if #(.CNT_W(32)) bus_a ();
    hazard_control_unit_if #(.CNT_W(3))  bus_b ();

    hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .io_hcu(bus_a)
    );
    hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .io_hcu(bus_b)
    );

    assign bus_b.id_rs1        = bus_a.id_rs1;
    assign bus_b.id_rs2        = bus_a.id_rs2;
    assign bus_b.id_uses_rs1   = bus_a.id_uses_rs1;
    assign bus_b.id_uses_rs2   = bus_a.id_uses_rs2;
    assign bus_b.ex_rs1        = bus_a.ex_rs1;
    assign bus_b.ex_rs2        = bus_a.ex_rs2;
    assign bus_b.ex_rd         = bus_a.ex_rd;
    assign bus_b.ex_mem_read   = bus_a.ex_mem_read;
    assign bus_b.ex_branch     = bus_a.ex_branch;
    assign bus_b.ex_zero       = bus_a.ex_zero;
    assign bus_b.ex_jump       = bus_a.ex_jump;
    assign bus_b.mem_rd        = bus_a.mem_rd;
    assign bus_b.mem_reg_write = bus_a.mem_reg_write;
    assign bus_b.mem_access    = bus_a.mem_access;
    assign bus_b.dmem_ready    = bus_a.dmem_ready;
    assign bus_b.wb_rd         = bus_a.wb_rd;
    assign bus_b.wb_reg_write  = bus_a.wb_reg_write;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic [4:0] mrd,
                                           input logic mwe, input logic [4:0] wrd,
                                           input logic wwe);
        if (mwe && mrd != 0 && mrd == rs) return 2'b10;
        if (wwe && wrd != 0 && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Model: how long the current memory access has been frozen, plus event counts
    int     age;
    bit     fault_m;
    bit     mvalid = 1'b0;
    longint st_a, fl_a, st_b, fl_b;

    always @(negedge clk) begin
        bit busy, take, lu, tmo, frz, fl, lus;
        busy = bus_a.mem_access && !bus_a.dmem_ready;
        take = (bus_a.ex_branch && bus_a.ex_zero) || bus_a.ex_jump;
        lu   = bus_a.ex_mem_read && bus_a.ex_rd != 0 &&
               ((bus_a.id_uses_rs1 && bus_a.id_rs1 == bus_a.ex_rd) ||
                (bus_a.id_uses_rs2 && bus_a.id_rs2 == bus_a.ex_rd));
        tmo  = busy && age == TO;
        frz  = busy && !tmo;
        fl   = !frz && take;
        lus  = !frz && !take && lu;
        if (mvalid) begin
            chk("m_fwd_a", bus_a.fwd_a, exp_fwd(bus_a.ex_rs1, bus_a.mem_rd, bus_a.mem_reg_write,
                                                bus_a.wb_rd, bus_a.wb_reg_write));
            chk("m_fwd_b", bus_a.fwd_b, exp_fwd(bus_a.ex_rs2, bus_a.mem_rd, bus_a.mem_reg_write,
                                                bus_a.wb_rd, bus_a.wb_reg_write));
            chk("m_pc_write",     bus_a.pc_write,     !(frz || lus));
            chk("m_if_id_write",  bus_a.if_id_write,  !(frz || lus));
            chk("m_pc_sel",       bus_a.pc_sel,       fl);
            chk("m_if_id_flush",  bus_a.if_id_flush,  fl);
            chk("m_id_ex_flush",  bus_a.id_ex_flush,  fl || lus);
            chk("m_global_stall", bus_a.global_stall, frz);
            chk("m_mem_abort",    bus_a.mem_abort,    tmo);
            chk("m_mem_fault",    bus_a.mem_fault,    fault_m);
            chk("m_state",        bus_a.state_o,      age != 0);
            chk("m_stall_a",      bus_a.stall_cycles, st_a);
            chk("m_flush_a",      bus_a.flush_count,  fl_a);
            chk("m_b_ctrl", {bus_b.pc_write, bus_b.pc_sel, bus_b.if_id_write, bus_b.if_id_flush,
                             bus_b.id_ex_flush, bus_b.global_stall, bus_b.mem_abort,
                             bus_b.mem_fault, bus_b.state_o},
                            {!(frz || lus), fl, !(frz || lus), fl, fl || lus, frz, tmo,
                             fault_m, age != 0});
            chk("m_stall_b", bus_b.stall_cycles, st_b);
            chk("m_flush_b", bus_b.flush_count,  fl_b);
        end
        if (!rst_n) begin
            age = 0; fault_m = 1'b0; mvalid = 1'b1;
            st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
        end else if (mvalid) begin
            fault_m = tmo;
            age     = frz ? age + 1 : 0;
            if (frz || lus) begin
                if (st_a < MAX_A) st_a++;
                if (st_b < MAX_B) st_b++;
            end
            if (fl) begin
                if (fl_a < MAX_A) fl_a++;
                if (fl_b < MAX_B) fl_b++;
            end
        end
    end

    task automatic clr();
        bus_a.id_rs1 = 0; bus_a.id_rs2 = 0; bus_a.id_uses_rs1 = 0; bus_a.id_uses_rs2 = 0;
        bus_a.ex_rs1 = 0; bus_a.ex_rs2 = 0; bus_a.ex_rd = 0; bus_a.ex_mem_read = 0;
        bus_a.ex_branch = 0; bus_a.ex_zero = 0; bus_a.ex_jump = 0;
        bus_a.mem_rd = 0; bus_a.mem_reg_write = 0; bus_a.mem_access = 0; bus_a.dmem_ready = 0;
        bus_a.wb_rd = 0; bus_a.wb_reg_write = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", bus_a.state_o, 0);
        chk("rst_stall", bus_a.stall_cycles, 0);
        chk("rst_flush", bus_a.flush_count, 0);
        chk("rst_fault", bus_a.mem_fault, 0);
        chk("rst_pc_write", bus_a.pc_write, 1);

        // Forwarding priority and x0
        tick();
        bus_a.mem_rd = 5; bus_a.mem_reg_write = 1; bus_a.wb_rd = 5; bus_a.wb_reg_write = 1;
        bus_a.ex_rs1 = 5;
        @(negedge clk);
        chk("fwd_a_mem", bus_a.fwd_a, 2'b10);
        chk("fwd_b_none", bus_a.fwd_b, 2'b00);
        tick();
        bus_a.ex_rs2 = 5; bus_a.mem_reg_write = 0;
        @(negedge clk);
        chk("fwd_b_wb", bus_a.fwd_b, 2'b01);
        chk("fwd_a_wb", bus_a.fwd_a, 2'b01);
        tick();
        bus_a.mem_reg_write = 1; bus_a.mem_rd = 0; bus_a.ex_rs1 = 0;
        @(negedge clk);
        chk("fwd_a_x0", bus_a.fwd_a, 2'b00);
        chk("fwd_b_wb2", bus_a.fwd_b, 2'b01);

        // Load-use
        tick(); clr();
        bus_a.ex_mem_read = 1; bus_a.ex_rd = 7; bus_a.id_rs2 = 7; bus_a.id_uses_rs2 = 1;
        @(negedge clk);
        chk("lu_pc_write", bus_a.pc_write, 0);
        chk("lu_if_id_write", bus_a.if_id_write, 0);
        chk("lu_id_ex_flush", bus_a.id_ex_flush, 1);
        chk("lu_stall_before", bus_a.stall_cycles, 0);
        tick(); clr();
        @(negedge clk);
        chk("lu_stall_after", bus_a.stall_cycles, 1);
        chk("lu_released", bus_a.pc_write, 1);
        tick();
        bus_a.ex_mem_read = 1; bus_a.ex_rd = 0; bus_a.id_rs1 = 0; bus_a.id_uses_rs1 = 1;
        @(negedge clk);
        chk("lu_x0", bus_a.pc_write, 1);
        tick();
        bus_a.ex_rd = 7; bus_a.id_rs1 = 7; bus_a.id_uses_rs1 = 0;
        @(negedge clk);
        chk("lu_unused", bus_a.pc_write, 1);

        // Branch taken beats load-use; not-taken; jump
        tick(); clr();
        bus_a.ex_mem_read = 1; bus_a.ex_rd = 7; bus_a.id_rs2 = 7; bus_a.id_uses_rs2 = 1;
        bus_a.ex_branch = 1; bus_a.ex_zero = 1;
        @(negedge clk);
        chk("br_pc_sel", bus_a.pc_sel, 1);
        chk("br_if_id_flush", bus_a.if_id_flush, 1);
        chk("br_id_ex_flush", bus_a.id_ex_flush, 1);
        chk("br_pc_write", bus_a.pc_write, 1);
        tick(); clr();
        bus_a.ex_branch = 1; bus_a.ex_zero = 0;
        @(negedge clk);
        chk("br_flush_cnt", bus_a.flush_count, 1);
        chk("br_stall_cnt", bus_a.stall_cycles, 1);
        chk("br_not_taken", bus_a.pc_sel, 0);
        tick(); clr();
        bus_a.ex_jump = 1;
        @(negedge clk);
        chk("jmp_pc_sel", bus_a.pc_sel, 1);
        tick(); clr();
        @(negedge clk);
        chk("jmp_flush_cnt", bus_a.flush_count, 2);

        // Memory wait of three cycles, jump suppressed during the freeze
        tick();
        bus_a.mem_access = 1;
        @(negedge clk);
        chk("mw1_stall", bus_a.global_stall, 1);
        chk("mw1_state", bus_a.state_o, 0);
        tick();
        bus_a.ex_jump = 1;
        @(negedge clk);
        chk("mw2_stall", bus_a.global_stall, 1);
        chk("mw2_state", bus_a.state_o, 1);
        chk("mw2_no_flush", bus_a.pc_sel, 0);
        tick();
        bus_a.ex_jump = 0;
        @(negedge clk);
        chk("mw3_stall", bus_a.global_stall, 1);
        tick();
        bus_a.dmem_ready = 1;
        @(negedge clk);
        chk("mw_ready_stall", bus_a.global_stall, 0);
        chk("mw_ready_state", bus_a.state_o, 1);
        chk("mw_ready_pc", bus_a.pc_write, 1);
        tick(); clr();
        @(negedge clk);
        chk("mw_end_state", bus_a.state_o, 0);
        chk("mw_stall_cnt", bus_a.stall_cycles, 4);
        chk("mw_flush_cnt", bus_a.flush_count, 2);

        // Timeout after four frozen cycles
        tick();
        bus_a.mem_access = 1;
        repeat (TO) begin
            @(negedge clk);
            chk("to_stall", bus_a.global_stall, 1);
            chk("to_no_abort", bus_a.mem_abort, 0);
            tick();
        end
        @(negedge clk);
        chk("to_abort", bus_a.mem_abort, 1);
        chk("to_abort_stall", bus_a.global_stall, 0);
        chk("to_abort_state", bus_a.state_o, 1);
        chk("to_abort_nofault", bus_a.mem_fault, 0);
        tick(); clr();
        @(negedge clk);
        chk("to_fault", bus_a.mem_fault, 1);
        chk("to_state", bus_a.state_o, 0);
        chk("to_abort_off", bus_a.mem_abort, 0);
        chk("to_stall_a", bus_a.stall_cycles, 8);
        chk("to_stall_b_sat", bus_b.stall_cycles, 7);
        tick();
        @(negedge clk);
        chk("to_fault_pulse", bus_a.mem_fault, 0);

        // Access withdrawn during the wait
        tick();
        bus_a.mem_access = 1;
        tick();
        @(negedge clk);
        chk("drop_wait", bus_a.state_o, 1);
        tick();
        bus_a.mem_access = 0;
        @(negedge clk);
        chk("drop_stall", bus_a.global_stall, 0);
        tick();
        @(negedge clk);
        chk("drop_state", bus_a.state_o, 0);
        chk("drop_fault", bus_a.mem_fault, 0);

        // Synchronous reset in the middle of a wait
        tick();
        bus_a.mem_access = 1;
        tick();
        @(negedge clk);
        chk("rw_wait", bus_a.state_o, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_stall", bus_a.global_stall, 1);
        tick();
        rst_n = 1'b1; clr();
        @(negedge clk);
        chk("rw_state", bus_a.state_o, 0);
        chk("rw_stall_cnt", bus_a.stall_cycles, 0);
        chk("rw_flush_cnt", bus_a.flush_count, 0);
        chk("rw_fault", bus_a.mem_fault, 0);
        chk("rw_stall_b", bus_b.stall_cycles, 0);

        // Saturation of the narrow counters
        tick();
        bus_a.ex_mem_read = 1; bus_a.ex_rd = 7; bus_a.id_rs1 = 7; bus_a.id_uses_rs1 = 1;
        repeat (10) tick();
        clr();
        @(negedge clk);
        chk("sat_stall_a", bus_a.stall_cycles, 10);
        chk("sat_stall_b", bus_b.stall_cycles, 7);
        tick();
        bus_a.ex_jump = 1;
        repeat (9) tick();
        clr();
        @(negedge clk);
        chk("sat_flush_a", bus_a.flush_count, 9);
        chk("sat_flush_b", bus_b.flush_count, 7);
        chk("sat_stall_b_hold", bus_b.stall_cycles, 7);

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Sequences the 5-stage RISC-V pipeline around the per-instruction decoder.
- Produces operand forwarding selects, load-use stalls, branch/jump flushes and a global freeze while data memory is busy.
- Has a wait-state FSM with a timeout, plus saturating performance counters.
- Sits beside the pipeline registers and drives their write/flush enables and the PC write/select.

Parameters:
- MEM_TIMEOUT, 16, max wait-state cycles tolerated in MEM_WAIT before abort (≥2).
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5 each  source regs of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2
- ex_rs1, ex_rs2  in  5 each  source regs of instruction in EX
- ex_rd  in  5  dest reg in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch, ex_zero, ex_jump  in  1 each  branch flag, ALU zero, jump flag in EX
- mem_rd  in  5  dest reg in MEM
- mem_reg_write  in  1  MEM instruction writes a register
- mem_access  in  1  MEM instruction accesses data memory (MemRead|MemWrite)
- dmem_ready  in  1  data memory completes access this cycle
- wb_rd  in  5  dest reg in WB
- wb_reg_write  in  1  WB instruction writes a register
- pc_write  out  1  PC update enable
- pc_sel  out  1  1 = load branch/jump target
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  zero IF/ID
- id_ex_flush  out  1  insert bubble into ID/EX
- global_stall  out  1  freeze PC and all pipeline registers
- mem_abort  out  1  suppress MEM-stage side effects (timeout)
- mem_fault  out  1  one-cycle pulse on timeout
- fwd_a, fwd_b  out  2 each  00 = reg file, 10 = EX/MEM, 01 = MEM/WB
- state_o  out  1  0 = RUN, 1 = MEM_WAIT
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_count  out  CNT_W  saturating count of flush events

Behaviour:
- Reset (rst_n = 0 at posedge):
  - state RUN, wait counter 0, both performance counters 0, mem_fault 0.
  - Combinational outputs follow the inputs with state = RUN.
- Forwarding (combinational; same rule for fwd_b using ex_rs2):
  - fwd_a = 10 if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1.
  - Otherwise fwd_a = 01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1.
  - Otherwise fwd_a = 00. MEM has priority over WB.
- Event conditions:
  - mem_busy = mem_access & ~dmem_ready.
  - take = (ex_branch & ex_zero) | ex_jump.
  - load_use = ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority: memory freeze > flush > load-use.
- Freeze (mem_busy and no timeout):
  - global_stall = 1, pc_write = 0, if_id_write = 0.
  - Flush and load-use outputs are forced 0; the events are re-evaluated once the freeze clears.
- Flush (take, no freeze):
  - pc_sel = 1, pc_write = 1, if_id_flush = 1, id_ex_flush = 1 in the same cycle.
  - load_use is ignored in that cycle.
- Load-use (no freeze, no take):
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1 for exactly one cycle.
- Idle defaults: pc_write = 1, if_id_write = 1, all other control outputs 0.
- FSM:
  - RUN -> MEM_WAIT when mem_busy; wait counter loads 1.
  - MEM_WAIT with dmem_ready: global_stall = 0 that cycle, next state RUN, counter cleared.
  - MEM_WAIT, not ready, counter < MEM_TIMEOUT: counter increments.
  - MEM_WAIT, not ready, counter == MEM_TIMEOUT:
    - global_stall = 0 and mem_abort = 1 combinationally.
    - mem_fault registered high for the next cycle only; next state RUN.
  - mem_access dropping in MEM_WAIT (abnormal) returns to RUN with no fault.
- Counters:
  - stall_cycles increments on any cycle with global_stall = 1 or an active load-use stall.
  - flush_count increments on each flush cycle.
  - Both saturate at all-ones and never wrap.
- A synchronous reset mid-wait aborts the wait: state RUN, counter 0, no mem_fault pulse.
- Register x0 is never forwarded and never causes a stall.

Test Plan:
- EX/MEM forwarding: mem_rd = 5, mem_reg_write = 1, wb_rd = 5, wb_reg_write = 1, ex_rs1 = 5 -> fwd_a = 10. Then ex_rs2 = 5 with mem_reg_write = 0 -> fwd_b = 01. Then mem_rd = 0, ex_rs1 = 0 -> fwd_a = 00.
- Load-use: ex_mem_read = 1, ex_rd = 7, id_rs2 = 7, id_uses_rs2 = 1 -> one cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1; stall_cycles 0 -> 1.
- Branch taken with load-use in the same cycle: ex_branch = 1, ex_zero = 1 -> pc_sel = 1, if_id_flush = 1, id_ex_flush = 1, pc_write = 1; flush_count +1; stall_cycles unchanged.
- Memory wait: mem_access = 1, dmem_ready = 0 for 3 cycles, then 1 -> global_stall = 1 for 3 cycles and 0 on the ready cycle; state_o = 1 during the wait then 0; stall_cycles +3.
- Timeout (MEM_TIMEOUT = 4): dmem_ready held 0 -> global_stall = 1 for 4 cycles, then mem_abort = 1 with global_stall = 0; mem_fault = 1 the following cycle only; state_o returns 0.
- Reset mid-wait: rst_n = 0 during MEM_WAIT -> next edge state_o = 0, counters 0, mem_fault 0. Separately, stall_cycles preloaded near all-ones saturates and does not wrap.
